// File: rtl/band_matrix_loader_pkg.sv
// ============================================================================
// Module  : band_matrix_loader_pkg
// Brief   : Shared widths, feed-count constants, FSM encoding and band-order
//           element indices for the band matrix loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package band_matrix_loader_pkg;

    localparam int DW    = 8;
    localparam int NELEM = 44;
    localparam int CNT_W = 5;
    localparam int IDX_W = 6;

    localparam logic [CNT_W-1:0] LAST_CNT = 5'd21;
    localparam logic [CNT_W-1:0] CNT_IDLE = 5'd31;

    typedef enum logic {
        LOAD = 1'b0,
        FEED = 1'b1
    } state_t;

    // Row-major band order of the 8x8, half-bandwidth-4 matrix
    localparam logic [IDX_W-1:0] IDX_A11 = 6'd0,  IDX_A12 = 6'd1,  IDX_A13 = 6'd2,  IDX_A14 = 6'd3;
    localparam logic [IDX_W-1:0] IDX_A21 = 6'd4,  IDX_A22 = 6'd5,  IDX_A23 = 6'd6,  IDX_A24 = 6'd7,
                                 IDX_A25 = 6'd8;
    localparam logic [IDX_W-1:0] IDX_A31 = 6'd9,  IDX_A32 = 6'd10, IDX_A33 = 6'd11, IDX_A34 = 6'd12,
                                 IDX_A35 = 6'd13, IDX_A36 = 6'd14;
    localparam logic [IDX_W-1:0] IDX_A41 = 6'd15, IDX_A42 = 6'd16, IDX_A43 = 6'd17, IDX_A44 = 6'd18,
                                 IDX_A45 = 6'd19, IDX_A46 = 6'd20, IDX_A47 = 6'd21;
    localparam logic [IDX_W-1:0] IDX_A52 = 6'd22, IDX_A53 = 6'd23, IDX_A54 = 6'd24, IDX_A55 = 6'd25,
                                 IDX_A56 = 6'd26, IDX_A57 = 6'd27, IDX_A58 = 6'd28;
    localparam logic [IDX_W-1:0] IDX_A63 = 6'd29, IDX_A64 = 6'd30, IDX_A65 = 6'd31, IDX_A66 = 6'd32,
                                 IDX_A67 = 6'd33, IDX_A68 = 6'd34;
    localparam logic [IDX_W-1:0] IDX_A74 = 6'd35, IDX_A75 = 6'd36, IDX_A76 = 6'd37, IDX_A77 = 6'd38,
                                 IDX_A78 = 6'd39;
    localparam logic [IDX_W-1:0] IDX_A85 = 6'd40, IDX_A86 = 6'd41, IDX_A87 = 6'd42, IDX_A88 = 6'd43;

endpackage

`default_nettype wire

// File: rtl/band_matrix_loader_bank.sv
// ============================================================================
// Module  : band_bank
// Brief   : NELEM x DW register bank, one write port, full flat read bus.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module band_bank
    import band_matrix_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DW-1:0]         wdata,
    output logic [NELEM*DW-1:0]   rdata
);

    generate
        for (genvar k = 0; k < NELEM; k++) begin : g_elem
            logic [DW-1:0] elem_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    elem_q <= '0;
                end else if (we && (idx == IDX_W'(k))) begin
                    elem_q <= wdata;
                end
            end

            assign rdata[k*DW +: DW] = elem_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/band_matrix_loader.sv
// ============================================================================
// Module  : band_matrix_loader
// Brief   : Loads 44 band elements over valid/ready, holds them on a_flat and
//           sequences the 0..21 feed count. Define LOADER_DBUF_EN for a
//           front/back double-buffered bank pair.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module band_matrix_loader
    import band_matrix_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW-1:0]         in_data,
    input  logic                  feed_en,
    output logic [CNT_W-1:0]      count,
    output logic [NELEM*DW-1:0]   a_flat,
    output logic                  busy,
    output logic                  done
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               busy_q;
    logic               done_q, done_d;
    logic               w_accept;
    logic               w_last;

    assign w_accept = in_valid & in_ready;
    assign w_last   = w_accept & (wr_idx_q == IDX_A88);

`ifdef LOADER_DBUF_EN
    // sel_q names the front (feeding) bank; writes always target the other one
    logic               sel_q, sel_d;
    logic               back_full_q, back_full_d;
    logic [NELEM*DW-1:0] w_flat0, w_flat1;

    assign in_ready = (state_q == LOAD) | ~back_full_q;

    band_bank u_bank0 (
        .clk   (clk),
        .rst   (rst),
        .we    (w_accept & sel_q),
        .idx   (wr_idx_q),
        .wdata (in_data),
        .rdata (w_flat0)
    );

    band_bank u_bank1 (
        .clk   (clk),
        .rst   (rst),
        .we    (w_accept & ~sel_q),
        .idx   (wr_idx_q),
        .wdata (in_data),
        .rdata (w_flat1)
    );

    assign a_flat = sel_q ? w_flat1 : w_flat0;
`else
    assign in_ready = (state_q == LOAD);

    band_bank u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (w_accept),
        .idx   (wr_idx_q),
        .wdata (in_data),
        .rdata (a_flat)
    );
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        done_d   = 1'b0;
        wr_idx_d = wr_idx_q;
`ifdef LOADER_DBUF_EN
        sel_d       = sel_q;
        back_full_d = back_full_q;
`endif
        if (w_accept) begin
            wr_idx_d = w_last ? '0 : wr_idx_q + IDX_W'(1);
        end

        if (state_q == LOAD) begin
            if (w_last) begin
                state_d = FEED;
                count_d = '0;
`ifdef LOADER_DBUF_EN
                sel_d   = ~sel_q;
`endif
            end
        end else begin
`ifdef LOADER_DBUF_EN
            if (w_last) begin
                back_full_d = 1'b1;
            end
`endif
            if (feed_en) begin
                if (count_q == LAST_CNT) begin
                    done_d = 1'b1;
`ifdef LOADER_DBUF_EN
                    // A back bank completing this very cycle still chains directly
                    if (back_full_q | w_last) begin
                        sel_d       = ~sel_q;
                        back_full_d = 1'b0;
                        count_d     = '0;
                    end else begin
                        state_d = LOAD;
                        count_d = CNT_IDLE;
                    end
`else
                    state_d = LOAD;
                    count_d = CNT_IDLE;
`endif
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LOAD;
            wr_idx_q <= '0;
            count_q  <= CNT_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            count_q  <= count_d;
            busy_q   <= (count_d != CNT_IDLE);
            done_q   <= done_d;
        end
    end

`ifdef LOADER_DBUF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q       <= 1'b0;
            back_full_q <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            back_full_q <= back_full_d;
        end
    end
`endif

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_band_matrix_loader.sv
// ============================================================================
// Module  : tb_band_matrix_loader
// Brief   : Self-checking bench for band_matrix_loader (single or LOADER_DBUF_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_band_matrix_loader;
    import band_matrix_loader_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [7:0]          in_data = 8'h00;
    logic                feed_en = 1'b0;
    logic [4:0]          count;
    logic [351:0]        a_flat;
    logic                busy;
    logic                done;

    always #5 clk = ~clk;

    band_matrix_loader dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .feed_en  (feed_en),
        .count    (count),
        .a_flat   (a_flat),
        .busy     (busy),
        .done     (done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference: matrices as byte arrays, feed position -1 meaning idle
    byte unsigned m_front[44];
    byte unsigned m_back[44];
    int           m_nload = 0;
    int           m_pos   = -1;
    bit           m_done  = 1'b0;

    function automatic bit m_ready();
`ifdef LOADER_DBUF_EN
        return (m_pos < 0) || (m_nload < 44);
`else
        return (m_pos < 0);
`endif
    endfunction

    function automatic logic [351:0] m_flat();
        logic [351:0] f;
        for (int k = 0; k < 44; k++) f[k*8 +: 8] = m_front[k];
        return f;
    endfunction

    task automatic model_edge(input bit r, input bit v, input logic [7:0] d, input bit fe);
        bit acc;
        bit was_idle;
        if (r) begin
            for (int k = 0; k < 44; k++) begin
                m_front[k] = 8'h00;
                m_back[k]  = 8'h00;
            end
            m_nload = 0;
            m_pos   = -1;
            m_done  = 1'b0;
            return;
        end
        acc      = v && m_ready();
        was_idle = (m_pos < 0);
        m_done   = 1'b0;
        if (acc) begin
`ifdef LOADER_DBUF_EN
            m_back[m_nload] = d;
`else
            m_front[m_nload] = d;
`endif
            m_nload++;
        end
        if (!was_idle && fe) begin
            if (m_pos == 21) begin
                m_done = 1'b1;
                m_pos  = -1;
`ifdef LOADER_DBUF_EN
                if (m_nload == 44) begin
                    m_front = m_back;
                    m_nload = 0;
                    m_pos   = 0;
                end
`endif
            end else begin
                m_pos++;
            end
        end else if (was_idle && m_nload == 44) begin
`ifdef LOADER_DBUF_EN
            m_front = m_back;
`endif
            m_nload = 0;
            m_pos   = 0;
        end
    endtask

    task automatic check(input string nm, input logic [351:0] act, input logic [351:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // One clock: drive inputs, advance model on the edge, compare #1 later
    task automatic tick(input bit r, input bit v, input logic [7:0] d, input bit fe);
        logic [4:0] ec;
        rst = r; in_valid = v; in_data = d; feed_en = fe;
        @(posedge clk);
        model_edge(r, v, d, fe);
        #1;
        cyc++;
        ec = (m_pos < 0) ? 5'd31 : 5'(m_pos);
        n_tests++;
        if (count !== ec || busy !== (m_pos >= 0) || done !== m_done ||
            in_ready !== m_ready() || a_flat !== m_flat()) begin
            n_fail++;
            $display("FAIL model cycle %0d: count %0d/%0d busy %b/%b done %b/%b rdy %b/%b flat %h exp %h",
                     cyc, count, ec, busy, (m_pos >= 0), done, m_done, in_ready, m_ready(),
                     a_flat, m_flat());
        end
    endtask

    task automatic load_matrix(input int base, input bit fe);
        for (int k = 0; k < 44; k++) tick(1'b0, 1'b1, 8'(base + k), fe);
        in_valid = 1'b0;
    endtask

    task automatic run_to_done(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b1);
            if (done) seen = 1'b1;
        end
        check(nm, 352'(seen), 352'(1));
    endtask

    function automatic logic [351:0] ramp(input int base);
        logic [351:0] f;
        for (int k = 0; k < 44; k++) f[k*8 +: 8] = 8'(base + k);
        return f;
    endfunction

    typedef struct {
        bit         r;
        bit         v;
        logic [7:0] d;
        bit         fe;
        logic [4:0] c;
        bit         rdy;
        bit         bz;
        bit         dn;
    } vec_t;

    vec_t vt[6];

    initial begin
        logic [351:0] snap;
        int           busy_cycles;
        int           accepts;
        int           nxt;

        vt[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b1, 8'hAA, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0};
        vt[2] = '{1'b0, 1'b0, 8'h55, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0};
        vt[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0};
        vt[4] = '{1'b0, 1'b1, 8'h11, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0};
        vt[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 6; i++) begin
            tick(vt[i].r, vt[i].v, vt[i].d, vt[i].fe);
            check($sformatf("vec%0d_count", i), 352'(count), 352'(vt[i].c));
            check($sformatf("vec%0d_ready", i), 352'(in_ready), 352'(vt[i].rdy));
            check($sformatf("vec%0d_busy", i), 352'(busy), 352'(vt[i].bz));
            check($sformatf("vec%0d_done", i), 352'(done), 352'(vt[i].dn));
        end
        check("reset_flat", a_flat, '0);

        // First matrix, feed_en held high
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        load_matrix(1, 1'b1);
        check("feed_start_count", 352'(count), 352'(0));
        check("feed_start_busy", 352'(busy), 352'(1));
        check("a11", 352'(a_flat[7:0]), 352'(1));
        check("a88", 352'(a_flat[351:344]), 352'(44));
        for (int i = 1; i <= 21; i++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b1);
            check($sformatf("feed_count%0d", i), 352'(count), 352'(i));
`ifdef LOADER_DBUF_EN
            if (i == 1) check("ready_in_feed", 352'(in_ready), 352'(1));
`else
            if (i == 1) check("ready_in_feed", 352'(in_ready), 352'(0));
`endif
        end
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        check("end_count", 352'(count), 352'(31));
        check("end_done", 352'(done), 352'(1));
        check("end_busy", 352'(busy), 352'(0));
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        check("done_pulse_once", 352'(done), 352'(0));

        // Feed stall at count 7
        load_matrix(50, 1'b1);
        busy_cycles = 1;
        for (int i = 0; i < 7; i++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b1);
            if (busy) busy_cycles++;
        end
        snap = a_flat;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b0);
            if (busy) busy_cycles++;
            check("stall_count", 352'(count), 352'(7));
            check("stall_busy", 352'(busy), 352'(1));
            check("stall_flat", a_flat, snap);
        end
        for (int i = 0; i < 40 && busy; i++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b1);
            if (busy) busy_cycles++;
        end
        check("stall_feed_len", 352'(busy_cycles), 352'(27));
        check("stall_flat_ramp", snap, ramp(50));

        // Reset after 20 accepts discards the partial load
        for (int k = 0; k < 20; k++) tick(1'b0, 1'b1, 8'(200 + k), 1'b1);
        tick(1'b1, 1'b0, 8'h00, 1'b1);
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        check("midload_rst_flat", a_flat, '0);
        load_matrix(100, 1'b1);
        check("reload_count", 352'(count), 352'(0));
        check("reload_flat", a_flat, ramp(100));
        run_to_done("reload_done");

        // Alternating valid with junk on idle cycles
        accepts = 0;
        nxt = 150;
        for (int i = 0; i < 200 && accepts < 44; i++) begin
            if (i % 2 == 0) begin
                if (in_ready) begin
                    accepts++;
                end
                tick(1'b0, 1'b1, 8'(nxt), 1'b1);
                nxt++;
            end else begin
                tick(1'b0, 1'b0, 8'($urandom), 1'b1);
            end
            if (accepts < 44) check("toggle_no_early_feed", 352'(busy), 352'(0));
        end
        check("toggle_accepts", 352'(accepts), 352'(44));
        check("toggle_count", 352'(count), 352'(0));
        check("toggle_flat", a_flat, ramp(150));
        run_to_done("toggle_done");

`ifdef LOADER_DBUF_EN
        // Second matrix streamed while the first is held in feed
        load_matrix(1, 1'b1);
        for (int k = 0; k < 44; k++) tick(1'b0, 1'b1, 8'(60 + k), 1'b0);
        check("dbuf_ready_drop", 352'(in_ready), 352'(0));
        tick(1'b0, 1'b1, 8'hEE, 1'b0);
        for (int i = 1; i <= 21; i++) tick(1'b0, 1'b0, 8'h00, 1'b1);
        check("dbuf_at21", 352'(count), 352'(21));
        check("dbuf_flat1", a_flat, ramp(1));
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        check("dbuf_wrap_count", 352'(count), 352'(0));
        check("dbuf_wrap_done", 352'(done), 352'(1));
        check("dbuf_wrap_busy", 352'(busy), 352'(1));
        check("dbuf_flat2", a_flat, ramp(60));
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        check("dbuf_done_once", 352'(done), 352'(0));
        check("dbuf_count1", 352'(count), 352'(1));
        run_to_done("dbuf_done2");
`endif

        // Randomized traffic against the reference
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
                 8'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
